// File: rtl/sram_responder_if.sv
// sram_responder_if: control and address pins of the 16-bit asynchronous SRAM bus.
// The bidirectional data bus SRAM_DQ is not carried here. It stays a plain inout
// on the responder so that the tri-state net is resolved at a single level.
//   master : the SRAM controller side, which drives every pin
//   slave  : the responder side, which samples every pin
interface sram_responder_if;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;

  modport master (
    output SRAM_ADDR, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N
  );

  modport slave (
    input SRAM_ADDR, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N
  );
endinterface

// File: rtl/sram_responder.sv
// sram_responder: synthesizable stand-in for an external 16-bit asynchronous SRAM.
// It provides byte-lane writes and pipelined reads with a latency of READ_LATENCY
// edges. It also keeps access counters and sticky flags for contention and for
// out-of-range addresses.
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   bus       SRAM control/address pins (slave modport)
//   SRAM_DQ   bidirectional data, driven only while read data is being output
//   wr_count  accepted write cycles (wraps)
//   rd_count  accepted read launches (wraps)
//   conflict  sticky: write seen while read data was being output
//   oob       sticky: access with address bits above ADDR_BITS set
module sram_responder #(
  parameter int ADDR_BITS    = 18,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  sram_responder_if.slave   bus,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count,
  output logic              conflict,
  output logic              oob
);

  localparam int DEPTH = 1 << ADDR_BITS;
  // Marks address bits above the implemented range. It is all zero when ADDR_BITS=18.
  localparam logic [17:0] HI_MASK = ~((18'd1 << ADDR_BITS) - 18'd1);

  logic [15:0] mem [DEPTH];

  logic [ADDR_BITS-1:0] addr;
  logic                 in_range;
  logic                 wr_cyc;
  logic                 rd_cyc;

  assign addr     = bus.SRAM_ADDR[ADDR_BITS-1:0];
  assign in_range = ((bus.SRAM_ADDR & HI_MASK) == 18'd0);
  assign wr_cyc   = ~bus.SRAM_CE_N & ~bus.SRAM_WE_N;
  assign rd_cyc   = ~bus.SRAM_CE_N &  bus.SRAM_WE_N;

  // Read pipeline. Stage 0 is loaded at launch. The last stage is the output stage.
  logic        pipe_vld   [READ_LATENCY];
  logic [15:0] pipe_data  [READ_LATENCY];
  logic [1:0]  pipe_lanes [READ_LATENCY];

  logic        out_vld;
  logic [15:0] out_data;
  logic [1:0]  out_lanes;
  logic        drive_en;
  logic [15:0] drive_val;

  assign out_vld   = pipe_vld[READ_LATENCY-1];
  assign out_data  = pipe_data[READ_LATENCY-1];
  assign out_lanes = pipe_lanes[READ_LATENCY-1];

  // Reset takes priority over a write, so the memory array still observes rst.
  always_ff @(posedge clk) begin
    if (!rst && wr_cyc && in_range) begin
      if (!bus.SRAM_LB_N) mem[addr][7:0]  <= SRAM_DQ[7:0];
      if (!bus.SRAM_UB_N) mem[addr][15:8] <= SRAM_DQ[15:8];
    end
  end

  // The data and lane fields are qualified by the valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    pipe_data[0]  <= in_range ? mem[addr] : 16'h0000;
    pipe_lanes[0] <= {bus.SRAM_UB_N, bus.SRAM_LB_N};
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_data[i]  <= pipe_data[i-1];
      pipe_lanes[i] <= pipe_lanes[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe_vld[i] <= 1'b0;
      wr_count <= 16'h0000;
      rd_count <= 16'h0000;
      conflict <= 1'b0;
      oob      <= 1'b0;
    end else begin
      pipe_vld[0] <= rd_cyc;
      for (int i = 1; i < READ_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
      if (wr_cyc) wr_count <= wr_count + 16'h0001;
      if (rd_cyc) rd_count <= rd_count + 16'h0001;
      if (wr_cyc && out_vld) conflict <= 1'b1;
      if (!bus.SRAM_CE_N && !in_range) oob <= 1'b1;
    end
  end

  // WE_N low blocks the drive, so the bus is released during a conflicting write.
  always_comb begin
    drive_en  = out_vld & ~bus.SRAM_CE_N & ~bus.SRAM_OE_N & bus.SRAM_WE_N;
    drive_val = {out_lanes[1] ? 8'h00 : out_data[15:8],
                 out_lanes[0] ? 8'h00 : out_data[7:0]};
  end

  assign SRAM_DQ = drive_en ? drive_val : 16'bz;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: randomized and directed stimulus checked against a timeline
// model. The model records the data for every launch, indexed by edge number.
// Edge e shows the launch from edge e-READ_LATENCY+1 on the bus, unless a reset
// has happened since that launch.
module tb_sram_responder;
  localparam int AB   = 10;
  localparam int LAT  = 2;
  localparam int MAXE = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_responder_if bus();
  wire  [15:0] dq;
  logic [15:0] tb_dq    = 16'h0000;
  logic        tb_dq_en = 1'b0;
  logic [15:0] wr_count, rd_count;
  logic        conflict, oob;

  assign dq = tb_dq_en ? tb_dq : 16'bz;

  sram_responder #(.ADDR_BITS(AB), .READ_LATENCY(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .SRAM_DQ  (dq),
    .wr_count (wr_count),
    .rd_count (rd_count),
    .conflict (conflict),
    .oob      (oob)
  );

  int total = 0;
  int bad   = 0;

  // model state
  logic [15:0] mm [1 << AB];
  bit          hv [MAXE];
  logic [15:0] hd [MAXE];
  logic [1:0]  hl [MAXE];
  int          ecount   = 0;
  int          last_rst = 0;
  logic [15:0] m_wr = 0, m_rd = 0;
  logic        m_conf = 0, m_oob = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%h exp=%h", tag, ecount, got, exp);
    end
  endtask

  function automatic logic [15:0] dq_ones();
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = (dq[i] === 1'b1);
    return r;
  endfunction

  function automatic bit lvalid(input int le);
    return (le >= 1) && (le < MAXE) && hv[le] && (le > last_rst);
  endfunction

  task automatic cyc(input bit r, input bit ce_n, input bit we_n, input bit oe_n,
                     input bit ub_n, input bit lb_n, input logic [17:0] ad,
                     input logic [15:0] wd);
    logic [15:0] exp;
    logic [AB-1:0] a;
    logic [17-AB:0] hi;
    int le;
    bit inr;
    @(negedge clk);
    rst = r;
    bus.SRAM_CE_N = ce_n;
    bus.SRAM_WE_N = we_n;
    bus.SRAM_OE_N = oe_n;
    bus.SRAM_UB_N = ub_n;
    bus.SRAM_LB_N = lb_n;
    bus.SRAM_ADDR = ad;
    tb_dq    = wd;
    tb_dq_en = !ce_n && !we_n;
    #1;
    if (ecount > 0) begin
      le = ecount - LAT + 1;
      if (lvalid(le) && !ce_n && !oe_n && we_n)
        exp = {hl[le][1] ? 8'h00 : hd[le][15:8], hl[le][0] ? 8'h00 : hd[le][7:0]};
      else if (tb_dq_en)
        exp = wd;
      else
        exp = 16'h0000;
      chk("dq", dq_ones(), exp);
    end
    @(posedge clk);
    ecount++;
    a   = ad[AB-1:0];
    hi  = ad[17:AB];
    inr = (hi == '0);
    hv[ecount] = 1'b0;
    if (r) begin
      last_rst = ecount;
      m_wr = 0; m_rd = 0; m_conf = 0; m_oob = 0;
    end else if (!ce_n) begin
      if (!inr) m_oob = 1'b1;
      if (!we_n) begin
        m_wr++;
        if (lvalid(ecount - LAT)) m_conf = 1'b1;
        if (inr) begin
          if (!lb_n) mm[a][7:0]  = wd[7:0];
          if (!ub_n) mm[a][15:8] = wd[15:8];
        end
      end else begin
        m_rd++;
        hv[ecount] = 1'b1;
        hd[ecount] = inr ? mm[a] : 16'h0000;
        hl[ecount] = {ub_n, lb_n};
      end
    end
    #1;
    chk("wr_count", wr_count, m_wr);
    chk("rd_count", rd_count, m_rd);
    chk("conflict", {15'd0, conflict}, {15'd0, m_conf});
    chk("oob", {15'd0, oob}, {15'd0, m_oob});
  endtask

  task automatic wr(input logic [17:0] ad, input logic [15:0] d, input bit ub_n, input bit lb_n);
    cyc(0, 0, 0, 0, ub_n, lb_n, ad, d);
  endtask

  task automatic rd(input logic [17:0] ad, input bit ub_n, input bit lb_n);
    cyc(0, 0, 1, 0, ub_n, lb_n, ad, 16'h0000);
  endtask

  task automatic idle();
    cyc(0, 1, 1, 1, 1, 1, 18'h0, 16'h0000);
  endtask

  initial begin
    bus.SRAM_ADDR = 18'h0;
    bus.SRAM_WE_N = 1'b1;
    bus.SRAM_UB_N = 1'b1;
    bus.SRAM_LB_N = 1'b1;
    bus.SRAM_CE_N = 1'b1;
    bus.SRAM_OE_N = 1'b1;

    cyc(1, 1, 1, 1, 1, 1, 18'h0, 16'h0);
    cyc(1, 1, 1, 1, 1, 1, 18'h0, 16'h0);
    // give every word a known value
    for (int i = 0; i < (1 << AB); i++) wr(18'(i), 16'($urandom), 0, 0);
    cyc(1, 1, 1, 1, 1, 1, 18'h0, 16'h0);

    // basic write / back-to-back read
    wr(18'h00A, 16'hBEEF, 0, 0);
    wr(18'h00B, 16'hDEAD, 0, 0);
    rd(18'h00A, 0, 0);
    rd(18'h00B, 0, 0);
    rd(18'h00A, 0, 0);
    rd(18'h00A, 0, 0);
    idle();
    chk("plan_wr2", wr_count, 16'd2);

    // byte lanes
    wr(18'h020, 16'h1234, 0, 0);
    wr(18'h020, 16'hABCD, 1, 0);
    rd(18'h020, 0, 0);
    rd(18'h020, 0, 1);
    rd(18'h020, 0, 0);
    rd(18'h020, 0, 0);
    idle();

    // conflict: the write lands while the launch from two edges back is on the bus
    rd(18'h00A, 0, 0);
    rd(18'h00A, 0, 0);
    wr(18'h00A, 16'h5555, 0, 0);
    chk("plan_conflict", {15'd0, conflict}, 16'd1);
    rd(18'h00A, 0, 0);
    rd(18'h00A, 0, 0);
    rd(18'h00A, 0, 0);
    idle();

    // out of range
    wr(18'h00400, 16'h7777, 0, 0);
    chk("plan_oob", {15'd0, oob}, 16'd1);
    rd(18'h00000, 0, 0);
    rd(18'h00400, 0, 0);
    rd(18'h00000, 0, 0);
    rd(18'h00000, 0, 0);
    idle();

    // reset while a read is in flight
    rd(18'h00A, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 18'h00A, 16'h0);
    chk("plan_rst_rd", rd_count, 16'd0);
    chk("plan_rst_flags", {14'd0, conflict, oob}, 16'd0);
    rd(18'h00A, 0, 0);
    rd(18'h00A, 0, 0);
    rd(18'h00A, 0, 0);
    idle();

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      bit r, ce_n, we_n, oe_n;
      logic [17:0] ad;
      r    = ($urandom_range(0, 99) == 0);
      ce_n = ($urandom_range(0, 4) == 0);
      we_n = ($urandom_range(0, 2) != 0);
      oe_n = ($urandom_range(0, 7) == 0);
      ad   = 18'($urandom_range(0, 31));
      if ($urandom_range(0, 49) == 0) ad[17:AB] = 8'($urandom_range(1, 255));
      cyc(r, ce_n, we_n, oe_n, 1'($urandom), 1'($urandom), ad, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable on-chip stand-in for the external 16-bit asynchronous SRAM chip.
- Sits on the far side of the SRAM pin bus: SRAM_DQ, SRAM_ADDR, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N.
- Lets the memory stage and SRAM controller run end-to-end in simulation and on boards without the chip.
- Provides byte-lane writes, pipelined reads with configurable latency, bus-contention detection, out-of-range detection and access counters.

Parameters:
- ADDR_BITS, 18: implemented word-address bits; the array holds 2^ADDR_BITS 16-bit words.
- READ_LATENCY, 1: clock edges from read launch to data on DQ; legal range 1..4.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- SRAM_DQ  inout  16  bidirectional data bus; this block drives it only during read output
- SRAM_ADDR  input  18  word address
- SRAM_WE_N  input  1  write enable, active low
- SRAM_UB_N  input  1  upper byte enable, active low
- SRAM_LB_N  input  1  lower byte enable, active low
- SRAM_CE_N  input  1  chip enable, active low
- SRAM_OE_N  input  1  output enable, active low
- wr_count  output  16  accepted write cycles; wraps
- rd_count  output  16  accepted read launches; wraps
- conflict  output  1  sticky: write attempted while read data was being output
- oob  output  1  sticky: access with SRAM_ADDR[17:ADDR_BITS] nonzero

Behaviour:
Reset (rst high at a rising edge):
- wr_count=0, rd_count=0, conflict=0, oob=0.
- All read-pipeline valid bits cleared; SRAM_DQ is Z from the cycle after the edge.
- Memory contents are not reset.
- Reset mid-read: data in flight is discarded and never driven.

Access decode, sampled each rising edge, rst low:
- CE_N=1: idle. No write; an invalid entry enters the pipeline; counters hold.
- CE_N=0, WE_N=0: write cycle.
  - mem[a][7:0] <= DQ[7:0] if LB_N=0; mem[a][15:8] <= DQ[15:8] if UB_N=0.
  - a = SRAM_ADDR[ADDR_BITS-1:0].
  - wr_count increments by 1, even if both lanes are masked.
- CE_N=0, WE_N=1: read launch.
  - A pipeline entry {valid=1, data=mem[a], lanes={UB_N,LB_N}} enters stage 1.
  - rd_count increments.
  - OE_N does not gate the launch.

Read pipeline:
- READ_LATENCY stages, shifting one per edge.
- The stage READ_LATENCY output is "out".
- Latency 1: address presented in cycle N; data on DQ throughout cycle N+1.
- Back-to-back reads at addresses A, A+1 yield data for A in N+1 and for A+1 in N+2 (full throughput).
- Read data reflects memory after any write committed at an earlier edge. A write at edge E is visible to a read launched at edge E+1.

DQ drive:
- SRAM_DQ = out.data when out.valid & ~CE_N & ~OE_N & WE_N; otherwise 16'bz.
- Lanes whose enable was high at launch are driven 8'h00.
- Drive is combinational from registered state plus current control pins.

Conflict:
- Set when WE_N=0 & CE_N=0 while out.valid=1 at a rising edge.
- In that cycle the block does not drive DQ; the write proceeds normally.
- Conflict stays set until reset.

Out of range:
- Condition: an access (CE_N=0) with any of SRAM_ADDR[17:ADDR_BITS] set. Not applicable when ADDR_BITS=18.
- Effect: oob is set (sticky); a write is dropped; a read launches with data 16'h0000.
- Counters still increment.

Wrap:
- Counters wrap 16'hFFFF -> 16'h0000.
- Address has no wrap: full decode, low bits only.

Simultaneous events:
- rst has priority over every access in the same cycle.
- A write and a pipeline shift in the same edge are both performed.

Test Plan:
- Reset, then write addr 18'h00A DQ=16'hBEEF and addr 18'h00B DQ=16'hDEAD (UB_N=LB_N=0, OE_N=0), then read launches at 00A, 00B -> DQ=BEEF one cycle after first launch, DEAD the next; wr_count=2, rd_count=2, DQ Z otherwise.
- Byte lanes: write 16'h1234 to 18'h020, then write 16'hABCD with UB_N=1, LB_N=0 -> read returns 16'h12CD; read with LB_N=1 -> DQ=16'h1200.
- READ_LATENCY=3: read launch at 00A in cycle N -> DQ=BEEF only in cycle N+3; three back-to-back launches -> data in N+3, N+4, N+5.
- Conflict: launch read at 00A, assert WE_N=0 with DQ=16'h5555 on the next edge (latency 1) -> conflict=1, DQ not driven by block, mem[00A]=5555 on later read.
- ADDR_BITS=10: write 16'h7777 to 18'h00400 -> oob=1, mem[000] unchanged; read of 18'h00400 -> DQ=16'h0000.
- rst asserted the edge after a read launch -> DQ stays Z, counters=0, flags=0; subsequent read of 00A still returns BEEF (memory retained).
